reg_file: RTL and testbench

Register array that consumes the 4-bit register addresses produced by the register decoder (`ext_Rd` = `{2'b11, Rd}` and `ext_Rp` = `{2'b10, Rp}`). It holds 16 × 8-bit registers and provides:
- two combinational read ports and one byte write port;
- a multi-cycle register-pair engine for 16-bit load, increment, decrement and read.

Pair p (p = 0..3) is formed as follows: high byte = reg `{2'b10,p}`, low byte = reg `{2'b11,p}`. The block sits between decode and the execute/write-back stage.

---
 rtl/reg_file.sv | 171 +++++++++++++++++
 tb/tb_reg_file.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 16 x DATA_W register array with two combinational read ports, one byte write
// port and a multi-cycle engine that loads, increments, decrements or reads register pairs.
module reg_file #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            rd_addr_a,
   output logic [DATA_W-1:0]     rd_data_a,
   input  logic [3:0]            rd_addr_b,
   output logic [DATA_W-1:0]     rd_data_b,
   input  logic                  wr_en,
   input  logic [3:0]            wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   output logic                  wr_ack,
   input  logic                  pr_start,
   input  logic [1:0]            pr_op,
   input  logic [3:0]            pr_addr,
   input  logic [2*DATA_W-1:0]   pr_wdata,
   output logic                  pr_busy,
   output logic                  pr_done,
   output logic [2*DATA_W-1:0]   pr_rdata,
   output logic                  pr_wrap
);

   localparam int PAIR_W = 2 * DATA_W;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WLO,
      S_WHI,
      S_DONE
   } state_t;

   // Returns {wrap, result}; arithmetic is modulo 2^PAIR_W.
   function automatic logic [PAIR_W:0] pair_step(input logic [1:0]        op,
                                                  input logic [PAIR_W-1:0] cur,
                                                  input logic [PAIR_W-1:0] ld);
      logic [PAIR_W:0] r;
      case (op)
         OP_LOAD: r = {1'b0, ld};
         OP_INC:  r = {(&cur), cur + PAIR_W'(1)};
         OP_DEC:  r = {(~|cur), cur - PAIR_W'(1)};
         default: r = {1'b0, cur};
      endcase
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [1:0]          idx_q, idx_d;
   logic [PAIR_W-1:0]   ldata_q, ldata_d;
   logic [PAIR_W-1:0]   res_q, res_d;
   logic                wrap_pend_q, wrap_pend_d;
   logic [PAIR_W-1:0]   rdata_q, rdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wrap_q, wrap_d;
   logic [DATA_W-1:0]   regs_q [16];
   logic [DATA_W-1:0]   regs_d [16];

   logic [3:0]          hi_addr;
   logic [3:0]          lo_addr;
   logic [PAIR_W-1:0]   pair_cur;
   logic [PAIR_W:0]     step;
   logic                pair_wr_phase;
   logic                unused_pr_addr;

   assign hi_addr        = {2'b10, idx_q};
   assign lo_addr        = {2'b11, idx_q};
   assign pair_cur       = {regs_q[hi_addr], regs_q[lo_addr]};
   assign step           = pair_step(op_q, pair_cur, ldata_q);
   assign pair_wr_phase  = (state_q == S_WLO) || (state_q == S_WHI);
   assign unused_pr_addr = ^pr_addr[3:2];

   assign wr_ack    = wr_en & ~pair_wr_phase;
   assign rd_data_a = regs_q[rd_addr_a];
   assign rd_data_b = regs_q[rd_addr_b];
   assign pr_busy   = busy_q;
   assign pr_done   = done_q;
   assign pr_rdata  = rdata_q;
   assign pr_wrap   = wrap_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      ldata_d     = ldata_q;
      res_d       = res_q;
      wrap_pend_d = wrap_pend_q;
      rdata_d     = rdata_q;
      wrap_d      = wrap_q;
      regs_d      = regs_q;

      // The byte port and the pair engine never write in the same cycle.
      if (wr_ack) begin
         regs_d[wr_addr] = wr_data;
      end

      case (state_q)
         S_IDLE: begin
            if (pr_start) begin
               op_d    = pr_op;
               idx_d   = pr_addr[1:0];
               ldata_d = pr_wdata;
               state_d = S_RD;
            end
         end
         S_RD: begin
            rdata_d     = pair_cur;
            res_d       = step[PAIR_W-1:0];
            wrap_pend_d = step[PAIR_W];
            state_d     = (op_q == OP_READ) ? S_DONE : S_WLO;
         end
         S_WLO: begin
            regs_d[lo_addr] = res_q[DATA_W-1:0];
            state_d         = S_WHI;
         end
         S_WHI: begin
            regs_d[hi_addr] = res_q[PAIR_W-1:DATA_W];
            state_d         = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RD) || (state_d == S_WLO) || (state_d == S_WHI);
      done_d = (state_d == S_DONE);
      if (state_d == S_DONE) begin
         wrap_d = wrap_pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         rdata_q <= '0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         rdata_q <= rdata_d;
         regs_q  <= regs_d;
      end
   end

   // Operation operands are only consumed after IDLE latches them.
   always_ff @(posedge clk) begin
      op_q        <= op_d;
      idx_q       <= idx_d;
      ldata_q     <= ldata_d;
      res_q       <= res_d;
      wrap_pend_q <= wrap_pend_d;
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: operation-level reference model, a per-cycle
// compare process, directed scenarios with literal expectations and a random phase.
module tb_reg_file;

   logic        clk;
   logic        rst;
   logic [3:0]  rd_addr_a, rd_addr_b;
   logic [7:0]  rd_data_a, rd_data_b;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack;
   logic        pr_start;
   logic [1:0]  pr_op;
   logic [3:0]  pr_addr;
   logic [15:0] pr_wdata;
   logic        pr_busy, pr_done, pr_wrap;
   logic [15:0] pr_rdata;

   reg_file #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .pr_start(pr_start), .pr_op(pr_op), .pr_addr(pr_addr), .pr_wdata(pr_wdata),
      .pr_busy(pr_busy), .pr_done(pr_done), .pr_rdata(pr_rdata), .pr_wrap(pr_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: registers as a plain array, a pair operation as a count
   // of cycles since its start (read ops last 2 cycles, the others 4).
   logic [7:0] m_reg [16];
   int         m_age = 0;
   int         m_len = 4;
   logic [1:0] m_op = 2'd0;
   logic [1:0] m_idx = 2'd0;
   int         m_wdata = 0;
   int         m_res = 0;
   int         m_v;
   bit         m_wflag = 0;
   bit         m_wphase;
   bit         m_wrap = 0;
   int         m_rdata = 0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
         m_age = 0; m_op = 2'd0; m_len = 4; m_wrap = 0; m_rdata = 0; m_wflag = 0;
      end else begin
         m_len    = (m_op == 2'd3) ? 2 : 4;
         m_wphase = (m_op != 2'd3) && (m_age == 2 || m_age == 3);
         m_v      = m_reg[8 + m_idx] * 256 + m_reg[12 + m_idx];
         if (m_age == 1) begin
            m_rdata = m_v;
            case (m_op)
               2'd0: m_res = m_wdata;
               2'd1: m_res = (m_v + 1) % 65536;
               2'd2: m_res = (m_v + 65535) % 65536;
               default: m_res = m_v;
            endcase
            m_wflag = (m_op == 2'd1 && m_v == 65535) || (m_op == 2'd2 && m_v == 0);
         end
         if (wr_en && !m_wphase) m_reg[wr_addr] = wr_data;
         if (m_wphase && m_age == 2) m_reg[12 + m_idx] = 8'(m_res & 255);
         if (m_wphase && m_age == 3) m_reg[8 + m_idx] = 8'(m_res >> 8);
         if (m_age == 0) begin
            if (pr_start) begin
               m_op = pr_op; m_idx = pr_addr[1:0]; m_wdata = pr_wdata; m_age = 1;
            end
         end else if (m_age == m_len) begin
            m_age = 0;
         end else begin
            m_age++;
         end
         m_len = (m_op == 2'd3) ? 2 : 4;
         if (m_age != 0 && m_age == m_len) m_wrap = m_wflag;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rd_data_a", rd_data_a, m_reg[rd_addr_a]);
         chk("rd_data_b", rd_data_b, m_reg[rd_addr_b]);
         chk("wr_ack", wr_ack,
             wr_en && !((m_op != 2'd3) && (m_age == 2 || m_age == 3)));
         chk("pr_busy", pr_busy, (m_age >= 1 && m_age < m_len));
         chk("pr_done", pr_done, (m_age != 0 && m_age == m_len));
         chk("pr_rdata", pr_rdata, m_rdata);
         chk("pr_wrap", pr_wrap, m_wrap);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rdchk(input string name, input logic [3:0] addr, input logic [7:0] exp);
      rd_addr_a = addr;
      rd_addr_b = ~addr;
      @(negedge clk);
      chk(name, rd_data_a, exp);
      cyc();
   endtask

   // Runs one pair op from the start cycle (cycle 0) to the done pulse, with an
   // optional byte write in cycle wr_cyc and optional pr_start held while busy.
   task automatic pair_op(input logic [1:0] op, input logic [1:0] p, input logic [15:0] d,
                          input int wr_cyc, input logic [3:0] waddr, input logic [7:0] wdat,
                          input logic exp_ack, input bit hold, input int exp_lat);
      int lat;
      pr_start = 1'b1;
      pr_op    = op;
      pr_addr  = {2'($urandom_range(0, 3)), p};
      pr_wdata = d;
      wr_addr  = waddr;
      wr_data  = wdat;
      wr_en    = (wr_cyc == 0);
      if (wr_cyc == 0) begin
         @(negedge clk);
         chk("wr_ack_start", wr_ack, exp_ack);
      end
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
         cyc();
         pr_start = hold && (c < exp_lat);
         pr_op    = 2'($urandom_range(0, 3));
         pr_wdata = 16'($urandom);
         wr_en    = (c == wr_cyc);
         @(negedge clk);
         if (c == wr_cyc) chk("wr_ack_busy", wr_ack, exp_ack);
         if (pr_done) begin
            lat = c;
            break;
         end
      end
      pr_start = 1'b0;
      wr_en    = 1'b0;
      chk("latency", lat, exp_lat);
      cyc();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; rd_addr_a = 4'h0; rd_addr_b = 4'h0;
      wr_en = 1'b0; wr_addr = 4'h0; wr_data = 8'h00;
      pr_start = 1'b0; pr_op = 2'd0; pr_addr = 4'h0; pr_wdata = 16'h0;
      repeat (2) cyc();
      chk("rst_busy", pr_busy, 1'b0);
      chk("rst_done", pr_done, 1'b0);
      chk("rst_wrap", pr_wrap, 1'b0);
      chk("rst_rdata", pr_rdata, 16'h0000);
      chk("rst_reg0", rd_data_a, 8'h00);
      chk_en = 1;
      rst = 1'b0;

      // Byte writes, visible the cycle after the write edge.
      wr_en = 1'b1; wr_addr = 4'hC; wr_data = 8'h5A;
      cyc();
      wr_addr = 4'h3; wr_data = 8'h11; rd_addr_a = 4'hC;
      @(negedge clk);
      chk("byte_wr_C", rd_data_a, 8'h5A);
      cyc();
      wr_en = 1'b0; rd_addr_b = 4'h3;
      @(negedge clk);
      chk("byte_wr_3", rd_data_b, 8'h11);
      cyc();
      rdchk("untouched_reg5", 4'h5, 8'h00);

      // Pair load and read.
      pair_op(2'd0, 2'd1, 16'hBEEF, -1, 4'h0, 8'h00, 1'b0, 0, 4);
      rdchk("load_hi_9", 4'h9, 8'hBE);
      rdchk("load_lo_D", 4'hD, 8'hEF);
      pair_op(2'd3, 2'd1, 16'h0000, -1, 4'h0, 8'h00, 1'b0, 0, 2);
      chk("read_rdata", pr_rdata, 16'hBEEF);

      // Wrap behaviour.
      pair_op(2'd0, 2'd2, 16'hFFFF, -1, 4'h0, 8'h00, 1'b0, 0, 4);
      pair_op(2'd1, 2'd2, 16'h0000, -1, 4'h0, 8'h00, 1'b0, 0, 4);
      chk("inc_wrap", pr_wrap, 1'b1);
      rdchk("inc_wrap_hi", 4'hA, 8'h00);
      rdchk("inc_wrap_lo", 4'hE, 8'h00);
      pair_op(2'd2, 2'd2, 16'h0000, -1, 4'h0, 8'h00, 1'b0, 0, 4);
      chk("dec_wrap", pr_wrap, 1'b1);
      rdchk("dec_wrap_hi", 4'hA, 8'hFF);
      rdchk("dec_wrap_lo", 4'hE, 8'hFF);
      pair_op(2'd0, 2'd2, 16'h00FF, -1, 4'h0, 8'h00, 1'b0, 0, 4);
      chk("load_nowrap", pr_wrap, 1'b0);
      pair_op(2'd1, 2'd2, 16'h0000, -1, 4'h0, 8'h00, 1'b0, 0, 4);
      chk("inc_carry_nowrap", pr_wrap, 1'b0);
      rdchk("inc_carry_hi", 4'hA, 8'h01);
      rdchk("inc_carry_lo", 4'hE, 8'h00);

      // Port contention: dropped during WLO, accepted in the start cycle.
      pair_op(2'd1, 2'd2, 16'h0000, 2, 4'hE, 8'h77, 1'b0, 0, 4);
      rdchk("contend_wlo_lo", 4'hE, 8'h01);
      rdchk("contend_wlo_hi", 4'hA, 8'h01);
      pair_op(2'd1, 2'd2, 16'h0000, 0, 4'hE, 8'h40, 1'b1, 0, 4);
      rdchk("start_wr_lo", 4'hE, 8'h41);
      rdchk("start_wr_hi", 4'hA, 8'h01);

      // pr_start held while busy must not launch a second operation.
      pair_op(2'd0, 2'd0, 16'h1234, -1, 4'h0, 8'h00, 1'b0, 1, 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_second_op_busy", pr_busy, 1'b0);
         chk("no_second_op_done", pr_done, 1'b0);
         cyc();
      end
      pair_op(2'd3, 2'd0, 16'h0000, -1, 4'h0, 8'h00, 1'b0, 0, 2);
      chk("read_pair0", pr_rdata, 16'h1234);

      // Reset during WLO aborts the op.
      pr_start = 1'b1; pr_op = 2'd0; pr_addr = 4'h3; pr_wdata = 16'hAAAA;
      cyc();
      pr_start = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("abort_busy", pr_busy, 1'b0);
      chk("abort_rdata", pr_rdata, 16'h0000);
      for (int a = 0; a < 16; a++) begin
         rd_addr_a = 4'(a);
         @(negedge clk);
         chk("abort_reg_zero", rd_data_a, 8'h00);
         chk("abort_no_done", pr_done, 1'b0);
         cyc();
      end

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         rst       = ($urandom_range(0, 63) == 0);
         rd_addr_a = 4'($urandom);
         rd_addr_b = 4'($urandom);
         wr_en     = $urandom_range(0, 1) == 1;
         wr_addr   = ($urandom_range(0, 1) == 1) ? {2'b1, 2'($urandom)} : 4'($urandom);
         wr_data   = 8'($urandom);
         pr_start  = ($urandom_range(0, 3) == 0);
         pr_op     = 2'($urandom);
         pr_addr   = 4'($urandom);
         pr_wdata  = ($urandom_range(0, 3) == 0) ? 16'hFFFF :
                     ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
         cyc();
      end
      rst = 1'b0; wr_en = 1'b0; pr_start = 1'b0;
      repeat (6) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
